// File: rtl/hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : LEGv8 five-stage pipeline hazard controller. Covers load-use
//            stalls, taken-branch flushes and data-memory wait states.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_err
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;
  localparam logic [4:0]        c_XZR       = 5'd31;

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_MEM_WAIT  = 2'b01,
    ST_BR_SHADOW = 2'b10
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_err;

  logic       w_is_b;
  logic       w_is_cbz;
  logic       w_is_ldur;
  logic       w_is_stur;
  logic       w_src_a_vld;
  logic       w_src_b_vld;
  logic [4:0] w_src_a;
  logic [4:0] w_src_b;
  logic       w_src_match;
  logic       w_lu_hazard;
  logic       w_mem_stall;
  logic       w_unused;

  assign w_unused = ^id_instr[15:10];

  assign w_is_b    = (id_instr[31:26] == 6'b000101);
  assign w_is_cbz  = (id_instr[31:24] == 8'b10110100);
  assign w_is_ldur = (id_instr[31:21] == 11'b11111000010);
  assign w_is_stur = (id_instr[31:21] == 11'b11111000000);

  // Source slot A carries Rn (or Rt for CBZ); slot B carries Rt for STUR
  // and Rm for R-type.
  always_comb begin
    w_src_a_vld = 1'b0;
    w_src_b_vld = 1'b0;
    w_src_a     = id_instr[9:5];
    w_src_b     = id_instr[20:16];
    if (w_is_b) begin
      w_src_a_vld = 1'b0;
    end else if (w_is_cbz) begin
      w_src_a_vld = 1'b1;
      w_src_a     = id_instr[4:0];
    end else if (w_is_ldur) begin
      w_src_a_vld = 1'b1;
    end else if (w_is_stur) begin
      w_src_a_vld = 1'b1;
      w_src_b_vld = 1'b1;
      w_src_b     = id_instr[4:0];
    end else begin
      w_src_a_vld = 1'b1;
      w_src_b_vld = 1'b1;
    end
  end

  assign w_src_match = (w_src_a_vld && (w_src_a == ex_rd)) ||
                       (w_src_b_vld && (w_src_b == ex_rd));
  assign w_lu_hazard = id_valid && ex_mem_read && (ex_rd != c_XZR) && w_src_match;
  assign w_mem_stall = mem_req && !mem_ready;

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_hold   = 1'b0;
    if (!rst_n) begin
      idex_bubble = 1'b1;
    end else if (w_mem_stall) begin
      pipe_hold = 1'b1;
    end else if (ex_branch_taken) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_lu_hazard && (r_state != ST_BR_SHADOW)) begin
      idex_bubble = 1'b1;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall)          r_state <= ST_MEM_WAIT;
          else if (ex_branch_taken) r_state <= ST_BR_SHADOW;
          else                      r_state <= ST_RUN;
        end
        ST_MEM_WAIT: begin
          if (mem_ready) r_state <= ST_RUN;
          else           r_state <= ST_MEM_WAIT;
        end
        ST_BR_SHADOW: begin
          if (w_mem_stall)          r_state <= ST_MEM_WAIT;
          else if (ex_branch_taken) r_state <= ST_BR_SHADOW;
          else                      r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      if (!pc_write && (r_stall_cnt != c_CNT_MAX))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (ifid_flush && (r_flush_cnt != c_CNT_MAX))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      // wait_cnt parks at its terminal value; mem_err is sticky from then on.
      if (w_mem_stall) begin
        if (r_wait_cnt == c_WAIT_LAST) r_mem_err  <= 1'b1;
        else                           r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign state       = r_state;
  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;
  assign mem_err     = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl; two instances (default and
//            small counters/timeout) share stimulus and a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;

  localparam int CW_A = 16, TO_A = 64, CW_B = 2, TO_B = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_instr;
  logic        id_valid, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic [4:0]  ex_rd;

  logic a_pc, a_ifw, a_bub, a_iff, a_idf, a_hold, a_err;
  logic b_pc, b_ifw, b_bub, b_iff, b_idf, b_hold, b_err;
  logic [1:0]      a_state, b_state;
  logic [CW_A-1:0] a_stall, a_flush;
  logic [CW_B-1:0] b_stall, b_flush;

  hazard_ctrl #(.CNT_W(CW_A), .MEM_TIMEOUT(TO_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(a_pc), .ifid_write(a_ifw), .idex_bubble(a_bub), .ifid_flush(a_iff),
    .idex_flush(a_idf), .pipe_hold(a_hold), .state(a_state),
    .stall_count(a_stall), .flush_count(a_flush), .mem_err(a_err));

  hazard_ctrl #(.CNT_W(CW_B), .MEM_TIMEOUT(TO_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(b_pc), .ifid_write(b_ifw), .idex_bubble(b_bub), .ifid_flush(b_iff),
    .idex_flush(b_idf), .pipe_hold(b_hold), .state(b_state),
    .stall_count(b_stall), .flush_count(b_flush), .mem_err(b_err));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: 0=RUN, 1=MEM_WAIT, 2=BR_SHADOW
  int m_st;
  int m_stall[2];
  int m_flush[2];
  int m_wait[2];
  bit m_err[2];
  int cmax[2];
  int tmo[2];
  bit e_pc, e_ifw, e_bub, e_iff, e_idf, e_hold;

  function automatic logic [5:0] a_vec();
    return {a_pc, a_ifw, a_bub, a_iff, a_idf, a_hold};
  endfunction
  function automatic logic [5:0] b_vec();
    return {b_pc, b_ifw, b_bub, b_iff, b_idf, b_hold};
  endfunction
  function automatic logic [5:0] e_vec();
    return {e_pc, e_ifw, e_bub, e_iff, e_idf, e_hold};
  endfunction

  function automatic bit ref_lu();
    int q[$];
    if (id_instr[31:26] == 6'b000101) begin
    end else if (id_instr[31:24] == 8'b10110100) q.push_back(int'(id_instr[4:0]));
    else if (id_instr[31:21] == 11'b11111000010) q.push_back(int'(id_instr[9:5]));
    else if (id_instr[31:21] == 11'b11111000000) begin
      q.push_back(int'(id_instr[9:5])); q.push_back(int'(id_instr[4:0]));
    end else begin
      q.push_back(int'(id_instr[9:5])); q.push_back(int'(id_instr[20:16]));
    end
    if (!id_valid || !ex_mem_read || ex_rd == 5'd31) return 1'b0;
    foreach (q[i]) if (q[i] == int'(ex_rd)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_st = 0;
    for (int k = 0; k < 2; k++) begin
      m_stall[k] = 0; m_flush[k] = 0; m_wait[k] = 0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_eval();
    {e_pc, e_ifw, e_bub, e_iff, e_idf, e_hold} = 6'b0;
    if (!rst_n) e_bub = 1'b1;
    else if (mem_req && !mem_ready) e_hold = 1'b1;
    else if (ex_branch_taken) {e_pc, e_ifw, e_iff, e_idf} = 4'b1111;
    else if (ref_lu() && m_st != 2) e_bub = 1'b1;
    else {e_pc, e_ifw} = 2'b11;
  endtask

  task automatic model_edge();
    bit stall;
    if (!rst_n) begin model_reset(); return; end
    stall = mem_req && !mem_ready;
    for (int k = 0; k < 2; k++) begin
      if (!e_pc && m_stall[k] < cmax[k]) m_stall[k]++;
      if (e_iff && m_flush[k] < cmax[k]) m_flush[k]++;
      if (stall) begin
        if (m_wait[k] == tmo[k] - 1) m_err[k] = 1'b1;
        m_wait[k]++;
      end else m_wait[k] = 0;
    end
    case (m_st)
      0: m_st = stall ? 1 : (ex_branch_taken ? 2 : 0);
      1: m_st = mem_ready ? 0 : 1;
      default: m_st = stall ? 1 : (ex_branch_taken ? 2 : 0);
    endcase
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    id_instr = 32'h0; id_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  localparam logic [31:0] ADD_X5_X3_X4 = {11'b10001011000, 5'd4, 6'd0, 5'd3, 5'd5};
  localparam logic [31:0] ADD_X1_X31   = {11'b10001011000, 5'd31, 6'd0, 5'd31, 5'd1};
  localparam logic [31:0] B_FIELD3     = {6'b000101, 26'd3};
  localparam logic [31:0] CBZ_X3       = {8'b10110100, 19'd10, 5'd3};

  task automatic test_reset();
    rst_n = 1'b1;
    clear_inputs();
    #3 rst_n = 1'b0;
    mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (a_vec() !== 6'b001000) begin
      failures++; $display("FAIL reset_ctrl: got %b expected %b", a_vec(), 6'b001000);
    end
    checks++;
    if ({a_state, a_stall, a_flush, a_err} !== '0) begin
      failures++; $display("FAIL reset_regs: got state=%0d stall=%0d flush=%0d err=%0d expected 0",
                           a_state, a_stall, a_flush, a_err);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_instr = ADD_X5_X3_X4; id_valid = 1'b1;
    #1;
    checks++;
    if (a_vec() !== 6'b001000) begin
      failures++; $display("FAIL load_use_ctrl: got %b expected %b", a_vec(), 6'b001000);
    end
    tick();
    ex_mem_read = 1'b0;
    #1;
    checks++;
    if (a_vec() !== 6'b110000 || a_stall !== 16'd1) begin
      failures++; $display("FAIL load_use_after: got ctrl=%b stall=%0d expected ctrl=110000 stall=1",
                           a_vec(), a_stall);
    end
    tick();
  endtask

  task automatic test_xzr();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd31; id_instr = ADD_X1_X31; id_valid = 1'b1;
    #1;
    checks++;
    if (a_vec() !== 6'b110000) begin
      failures++; $display("FAIL xzr_no_stall: got %b expected %b", a_vec(), 6'b110000);
    end
    tick();
    ex_rd = 5'd3; id_instr = B_FIELD3;
    #1;
    checks++;
    if (a_vec() !== 6'b110000) begin
      failures++; $display("FAIL b_no_stall: got %b expected %b", a_vec(), 6'b110000);
    end
    tick();
    checks++;
    if (a_stall !== 16'd0) begin
      failures++; $display("FAIL xzr_stall_cnt: got %0d expected 0", a_stall);
    end
  endtask

  task automatic test_branch();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_instr = CBZ_X3; id_valid = 1'b1; ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (a_vec() !== 6'b110110) begin
      failures++; $display("FAIL branch_ctrl: got %b expected %b", a_vec(), 6'b110110);
    end
    tick();
    ex_branch_taken = 1'b0;
    #1;
    checks++;
    if (a_state !== 2'b10 || a_flush !== 16'd1) begin
      failures++; $display("FAIL branch_state: got state=%0d flush=%0d expected state=2 flush=1",
                           a_state, a_flush);
    end
    checks++;
    if (a_vec() !== 6'b110000) begin
      failures++; $display("FAIL shadow_suppress: got %b expected %b", a_vec(), 6'b110000);
    end
    tick();
    checks++;
    if (a_state !== 2'b00) begin
      failures++; $display("FAIL shadow_exit: got %0d expected 0", a_state);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (a_vec() !== 6'b000001) begin
        failures++; $display("FAIL mem_hold[%0d]: got %b expected %b", i, a_vec(), 6'b000001);
      end
      tick();
      checks++;
      if (a_state !== 2'b01) begin
        failures++; $display("FAIL mem_state[%0d]: got %0d expected 1", i, a_state);
      end
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (a_vec() !== 6'b110000 || a_stall !== 16'd5 || b_stall !== 2'd3) begin
      failures++; $display("FAIL mem_release: got ctrl=%b stall=%0d sat=%0d expected 110000 5 3",
                           a_vec(), a_stall, b_stall);
    end
    tick();
    checks++;
    if (a_state !== 2'b00) begin
      failures++; $display("FAIL mem_return: got %0d expected 0", a_state);
    end
  endtask

  task automatic test_timeout_overlap();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      #1;
      checks++;
      if (b_vec() !== 6'b000001) begin
        failures++; $display("FAIL overlap_hold[%0d]: got %b expected %b", i, b_vec(), 6'b000001);
      end
      tick();
      checks++;
      if (b_err !== (i >= 4)) begin
        failures++; $display("FAIL timeout[%0d]: got %0d expected %0d", i, b_err, (i >= 4));
      end
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (b_vec() !== 6'b110110) begin
      failures++; $display("FAIL release_flush: got %b expected %b", b_vec(), 6'b110110);
    end
    tick();
    ex_branch_taken = 1'b0; mem_req = 1'b0;
    checks++;
    if (b_err !== 1'b1 || a_err !== 1'b0 || a_flush !== 16'd1 || a_state !== 2'b00) begin
      failures++; $display("FAIL after_release: got err=%0d/%0d flush=%0d state=%0d expected 1/0 1 0",
                           b_err, a_err, a_flush, a_state);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (5) tick();
    checks++;
    if (a_state !== 2'b01 || b_err !== 1'b1) begin
      failures++; $display("FAIL pre_reset: got state=%0d err=%0d expected 1 1", a_state, b_err);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_state, a_stall, a_flush, a_err, b_state, b_stall, b_flush, b_err} !== '0) begin
      failures++; $display("FAIL async_reset: got a=%0d/%0d/%0d/%0d b=%0d/%0d/%0d/%0d expected 0",
                           a_state, a_stall, a_flush, a_err, b_state, b_stall, b_flush, b_err);
    end
    do_reset();
  endtask

  task automatic test_random();
    int regs[4] = '{1, 2, 3, 31};
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [4:0] r1, r2, r3;
      r1 = 5'(regs[$urandom_range(0, 3)]);
      r2 = 5'(regs[$urandom_range(0, 3)]);
      r3 = 5'(regs[$urandom_range(0, 3)]);
      case ($urandom_range(0, 4))
        0: id_instr = {6'b000101, 21'($urandom), r1};
        1: id_instr = {8'b10110100, 19'($urandom), r1};
        2: id_instr = {11'b11111000010, 9'($urandom), 2'b00, r2, r1};
        3: id_instr = {11'b11111000000, 9'($urandom), 2'b00, r2, r1};
        default: id_instr = {11'b10001011000, r3, 6'($urandom), r2, r1};
      endcase
      id_valid        = ($urandom_range(0, 7) != 0);
      ex_mem_read     = $urandom_range(0, 1) == 1;
      ex_rd           = 5'(regs[$urandom_range(0, 3)]);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_req         = ($urandom_range(0, 2) == 0);
      mem_ready       = ($urandom_range(0, 3) != 0);
      #1;
      model_eval();
      checks++;
      if (a_vec() !== e_vec() || b_vec() !== e_vec()) begin
        failures++; $display("FAIL rand_ctrl[%0d]: got %b/%b expected %b", n, a_vec(), b_vec(), e_vec());
      end
      checks++;
      if (a_state !== 2'(m_st) || b_state !== 2'(m_st)) begin
        failures++; $display("FAIL rand_state[%0d]: got %0d/%0d expected %0d", n, a_state, b_state, m_st);
      end
      checks++;
      if (a_stall !== 16'(m_stall[0]) || b_stall !== 2'(m_stall[1]) ||
          a_flush !== 16'(m_flush[0]) || b_flush !== 2'(m_flush[1])) begin
        failures++; $display("FAIL rand_cnt[%0d]: got %0d/%0d %0d/%0d expected %0d/%0d %0d/%0d", n,
                             a_stall, b_stall, a_flush, b_flush, m_stall[0], m_stall[1], m_flush[0], m_flush[1]);
      end
      checks++;
      if (a_err !== m_err[0] || b_err !== m_err[1]) begin
        failures++; $display("FAIL rand_err[%0d]: got %0d/%0d expected %0d/%0d", n, a_err, b_err, m_err[0], m_err[1]);
      end
      tick();
    end
  endtask

  initial begin
    cmax[0] = (1 << CW_A) - 1; cmax[1] = (1 << CW_B) - 1;
    tmo[0]  = TO_A;            tmo[1]  = TO_B;
    model_reset();
    clear_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_xzr();
    test_branch();
    test_mem_wait();
    test_timeout_overlap();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
